period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_if.sv | 23 ++
 rtl/period_meter.sv | 135 +++++++++++++
 tb/tb_period_meter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// Result/handshake bundle for period_meter: event and clear inputs, the result
// with its valid/ready handshake, and the sticky status flags.
interface period_meter_if #(
  parameter int WIDTH = 28
);
  logic             tick_in;
  logic             clear;
  logic             period_ready;
  logic [WIDTH-1:0] period_out;
  logic             period_valid;
  logic             overflow;
  logic             overrun;

  // slave: the meter itself; master: whoever drives events and consumes results
  modport slave (
    input  tick_in, clear, period_ready,
    output period_out, period_valid, overflow, overrun
  );
  modport master (
    output tick_in, clear, period_ready,
    input  period_out, period_valid, overflow, overrun
  );
endinterface

// File: rtl/period_meter.sv
// Measures the number of clock cycles between successive tick_in events.
// Optional macro PERIOD_METER_AVG_EN reports the mean of the last 4 periods.
module period_meter #(
  parameter int WIDTH = 28
) (
  input  logic          clock,
  input  logic          reset_b,
  period_meter_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MEASURE   = 2'd1;
  localparam logic [1:0] SATURATED = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             capture;
  logic             rearm;
  logic             sat_enter;

  logic [WIDTH-1:0] period_out_reg;
  logic             period_valid_reg;
  logic             overflow_reg;
  logic             overrun_reg;

  logic [WIDTH-1:0] result;
  logic             result_en;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    rearm      = 1'b0;
    sat_enter  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.tick_in) begin
          state_next = MEASURE;
          count_next = CNT_ONE;
        end
      end
      MEASURE: begin
        if (bus.tick_in) begin
          capture    = 1'b1;
          count_next = CNT_ONE;
        end else if (count_reg == CNT_MAX) begin
          // timeout: hold the counter at its ceiling rather than wrapping
          sat_enter  = 1'b1;
          state_next = SATURATED;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      SATURATED: begin
        if (bus.tick_in) begin
          rearm      = 1'b1;
          state_next = MEASURE;
          count_next = CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

`ifdef PERIOD_METER_AVG_EN
  // The new capture plus the previous three make up the 4-period window.
  logic [WIDTH-1:0] hist_reg [0:2];
  logic [1:0]       fill_reg;
  logic [WIDTH+1:0] sum;

  assign sum = {2'b00, count_reg} + {2'b00, hist_reg[0]}
             + {2'b00, hist_reg[1]} + {2'b00, hist_reg[2]};
  assign result    = sum[WIDTH+1:2];
  assign result_en = capture && (fill_reg == 2'd3);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      fill_reg <= '0;
      for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
    end else if (bus.clear || rearm) begin
      fill_reg <= '0;
      for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
    end else if (capture) begin
      hist_reg[0] <= count_reg;
      for (int i = 1; i < 3; i++) hist_reg[i] <= hist_reg[i-1];
      if (fill_reg != 2'd3) fill_reg <= fill_reg + 1'b1;
    end
  end
`else
  assign result    = count_reg;
  assign result_en = capture;
`endif

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      period_out_reg   <= '0;
      period_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
      overrun_reg      <= 1'b0;
    end else if (bus.clear) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      period_out_reg   <= '0;
      period_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (sat_enter) overflow_reg <= 1'b1;
      if (result_en) begin
        period_out_reg   <= result;
        period_valid_reg <= 1'b1;
        // a simultaneous consume means nothing was lost
        if (period_valid_reg && !bus.period_ready) overrun_reg <= 1'b1;
      end else if (period_valid_reg && bus.period_ready) begin
        period_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.period_out   = period_out_reg;
  assign bus.period_valid = period_valid_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 28-bit instance for the main function and
// a 4-bit instance for the saturation corner.
module tb_period_meter;

  logic clock;
  logic reset_b;

  period_meter_if #(.WIDTH(28)) ia ();
  period_meter_if #(.WIDTH(4))  ib ();

  period_meter #(.WIDTH(28)) dut_a (.clock(clock), .reset_b(reset_b), .bus(ia));
  period_meter #(.WIDTH(4))  dut_b (.clock(clock), .reset_b(reset_b), .bus(ib));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        tick;
    logic        clr;
    logic        rdy;
    logic        exp_valid;
    logic [27:0] exp_out;
    logic        exp_ovf;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [27:0] o,
                       input logic ovf, input logic ovr);
    chk({tag, " valid"},    28'(ia.period_valid), 28'(v));
    chk({tag, " out"},      ia.period_out, o);
    chk({tag, " overflow"}, 28'(ia.overflow), 28'(ovf));
    chk({tag, " overrun"},  28'(ia.overrun), 28'(ovr));
    $display("[%0t] %s: valid=%0b out=%0d ovf=%0b ovr=%0b", $time, tag,
             ia.period_valid, ia.period_out, ia.overflow, ia.overrun);
  endtask

  task automatic step(input logic t, input logic c, input logic r);
    @(negedge clock);
    ia.tick_in = t;
    ia.clear = c;
    ia.period_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic stepb(input logic t, input logic c, input logic r);
    @(negedge clock);
    ib.tick_in = t;
    ib.clear = c;
    ib.period_ready = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // {tick, clear, ready} -> {valid, out, overflow, overrun}
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 28'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 28'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 28'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 28'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 28'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 28'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 28'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 28'd2, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 28'd2, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 28'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 28'd1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 28'd0, 1'b0, 1'b0};

    reset_b = 1'b0;
    ia.tick_in = 1'b0; ia.clear = 1'b0; ia.period_ready = 1'b0;
    ib.tick_in = 1'b0; ib.clear = 1'b0; ib.period_ready = 1'b0;
    #12;
    chk_a("reset A", 1'b0, 28'd0, 1'b0, 1'b0);
    chk("reset B out", 28'(ib.period_out), 28'd0);
    chk("reset B flags", 28'({ib.period_valid, ib.overflow, ib.overrun}), 28'd0);
    @(negedge clock);
    reset_b = 1'b1;

`ifdef PERIOD_METER_AVG_EN
    // Periods 8, 8, 8, 12: nothing until the fourth capture, then (36>>2)=9.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 36; i++) begin
      step((i == 8 || i == 16 || i == 24 || i == 36), 1'b0, 1'b1);
      chk($sformatf("avg valid @%0d", i), 28'(ia.period_valid), 28'(i == 36));
    end
    chk_a("avg result", 1'b1, 28'd9, 1'b0, 1'b0);
`else
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].tick, vecs[i].clr, vecs[i].rdy);
      chk_a($sformatf("vec %0d", i), vecs[i].exp_valid, vecs[i].exp_out,
            vecs[i].exp_ovf, vecs[i].exp_ovr);
    end

    // One-cycle tick every 16 cycles, ready high: first tick only arms.
    for (int i = 0; i < 64; i++) begin
      step((i % 16) == 0, 1'b0, 1'b1);
      chk($sformatf("p16 valid @%0d", i), 28'(ia.period_valid),
          28'(i >= 16 && (i % 16) == 0));
      if (i >= 16 && (i % 16) == 0) chk($sformatf("p16 out @%0d", i), ia.period_out, 28'd16);
    end

    // Periods 10 then 12 with ready low -> overwrite and overrun.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_a("period 10", 1'b1, 28'd10, 1'b0, 1'b0);
    repeat (11) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_a("period 12 overrun", 1'b1, 28'd12, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk_a("consume", 1'b0, 28'd12, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_a("after consume", 1'b0, 28'd12, 1'b0, 1'b1);

    // WIDTH=4: one tick then 20 idle cycles -> overflow once the count hits 15.
    stepb(1'b0, 1'b1, 1'b1);
    stepb(1'b1, 1'b0, 1'b1);
    for (int j = 1; j <= 20; j++) begin
      stepb(1'b0, 1'b0, 1'b1);
      chk($sformatf("w4 overflow @%0d", j), 28'(ib.overflow), 28'(j >= 15));
    end
    stepb(1'b1, 1'b0, 1'b1);
    chk("w4 rearm valid", 28'(ib.period_valid), 28'd0);
    repeat (4) stepb(1'b0, 1'b0, 1'b1);
    stepb(1'b1, 1'b0, 1'b1);
    chk("w4 valid", 28'(ib.period_valid), 28'd1);
    chk("w4 out", 28'(ib.period_out), 28'd5);
    chk("w4 overflow sticky", 28'(ib.overflow), 28'd1);
    $display("[%0t] w4: valid=%0b out=%0d ovf=%0b", $time, ib.period_valid,
             ib.period_out, ib.overflow);
    @(negedge clock);
    ib.tick_in = 1'b0;
    ib.period_ready = 1'b0;

    // Asynchronous reset between edges, mid-measurement, with a pending result.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_a("pre-reset result", 1'b1, 28'd4, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2;
    reset_b = 1'b0;
    #1;
    chk_a("async reset A", 1'b0, 28'd0, 1'b0, 1'b0);
    chk("async reset B overflow", 28'(ib.overflow), 28'd0);
    chk("async reset B valid", 28'(ib.period_valid), 28'd0);
    @(negedge clock);
    reset_b = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk_a("post-reset arm", 1'b0, 28'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_a("post-reset period", 1'b1, 28'd2, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
